turn_arbiter: RTL and testbench

- Sequences play on the shared tic-tac-toe board registers. It grants the board to one player at a time, either X or O.
- Validates each requested square against current occupancy and issues one-cycle store pulses that feed the X and O board registers.
- Enforces a per-turn time limit and counts moves to detect a full board.
- Sits between the square-selection front end (button pad, random click) and the board registers. Its turn/state outputs drive the display logic.

---
 rtl/turn_arbiter.sv | 175 +++++++++++++++++
 tb/tb_turn_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/turn_arbiter.sv
// Turn sequencer for the shared tic-tac-toe board: validates moves, issues store pulses, enforces turn time limit.
// Optional TURN_ARBITER_AUTO_MOVE_EN: on timeout, auto-play the lowest free square instead of passing the turn.
module turn_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 500000000,
  parameter int unsigned TMR_W          = 29
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       new_game,
  input  logic       game_over,
  input  logic       req_x,
  input  logic [8:0] cuadro_x,
  input  logic       req_o,
  input  logic [8:0] cuadro_o,
  input  logic [8:0] x,
  input  logic [8:0] o,
  output logic [8:0] almacenar_x,
  output logic [8:0] almacenar_o,
  output logic       ack,
  output logic       nack,
  output logic       timeout,
  output logic       turnoX,
  output logic [3:0] move_count,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_X   = 3'd1,
    COMMIT_X = 3'd2,
    WAIT_O   = 3'd3,
    COMMIT_O = 3'd4,
    DONE     = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             turn_q, turn_d;
  logic [8:0]       ax_q, ax_d, ao_q, ao_d;
  logic             ack_q, ack_d, nack_q, nack_d, to_q, to_d;

  // Only the turn holder's request is looked at.
  logic       in_x, req, onehot, valid, tmr_exp;
  logic [8:0] sq;

  assign in_x    = (state_q == WAIT_X);
  assign req     = in_x ? req_x : req_o;
  assign sq      = in_x ? cuadro_x : cuadro_o;
  assign onehot  = (sq != 9'd0) && ((sq & (sq - 9'd1)) == 9'd0);
  assign valid   = req && onehot && ((sq & (x | o)) == 9'd0);
  assign tmr_exp = (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));

`ifdef TURN_ARBITER_AUTO_MOVE_EN
  logic [8:0] free_sq, auto_sq;
  logic       has_free;
  assign free_sq  = ~(x | o);
  assign auto_sq  = free_sq & (~free_sq + 9'd1);  // isolate lowest set bit
  assign has_free = |free_sq;
`endif

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      cnt_q   <= 4'd0;
      turn_q  <= 1'b1;
      ax_q    <= 9'd0;
      ao_q    <= 9'd0;
      ack_q   <= 1'b0;
      nack_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
      turn_q  <= turn_d;
      ax_q    <= ax_d;
      ao_q    <= ao_d;
      ack_q   <= ack_d;
      nack_q  <= nack_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (new_game) begin
      state_d = WAIT_X;
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        WAIT_X, WAIT_O: begin
          if (game_over)    state_d = DONE;
          else if (valid)   state_d = in_x ? COMMIT_X : COMMIT_O;
          else if (tmr_exp) begin
`ifdef TURN_ARBITER_AUTO_MOVE_EN
            if (has_free) state_d = in_x ? COMMIT_X : COMMIT_O;
            else          state_d = DONE;
`else
            state_d = in_x ? WAIT_O : WAIT_X;
`endif
          end
        end
        COMMIT_X: state_d = (cnt_q == 4'd8) ? DONE : WAIT_O;
        COMMIT_O: state_d = (cnt_q == 4'd8) ? DONE : WAIT_X;
        DONE:     state_d = DONE;
        default:  state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    timer_d = timer_q;
    cnt_d   = cnt_q;
    turn_d  = turn_q;
    ax_d    = 9'd0;
    ao_d    = 9'd0;
    ack_d   = 1'b0;
    nack_d  = 1'b0;
    to_d    = 1'b0;
    if (new_game) begin
      timer_d = '0;
      cnt_d   = 4'd0;
      turn_d  = 1'b1;
    end else begin
      case (state_q)
        WAIT_X, WAIT_O: begin
          if (game_over) begin
            timer_d = '0;
          end else if (valid) begin
            timer_d = '0;
            ack_d   = 1'b1;
            if (in_x) ax_d = sq;
            else      ao_d = sq;
          end else begin
            nack_d = req;
            if (tmr_exp) begin
              timer_d = '0;
              to_d    = 1'b1;
`ifdef TURN_ARBITER_AUTO_MOVE_EN
              if (has_free) begin
                ack_d = 1'b1;
                if (in_x) ax_d = auto_sq;
                else      ao_d = auto_sq;
              end
`else
              turn_d = ~turn_q;
`endif
            end else begin
              timer_d = timer_q + TMR_W'(1);
            end
          end
        end
        COMMIT_X, COMMIT_O: begin
          cnt_d   = cnt_q + 4'd1;
          turn_d  = ~turn_q;
          timer_d = '0;
        end
        default: timer_d = '0;
      endcase
    end
  end

  // A reset landing on the commit cycle must not write the board.
  assign almacenar_x = reset ? 9'd0 : ax_q;
  assign almacenar_o = reset ? 9'd0 : ao_q;
  assign ack         = ack_q;
  assign nack        = nack_q;
  assign timeout     = to_q;
  assign turnoX      = turn_q;
  assign move_count  = cnt_q;
  assign state       = state_q;

endmodule

// File: tb/tb_turn_arbiter.sv
// Directed plus randomized bench for turn_arbiter against a game-level reference model.
module tb_turn_arbiter;
  localparam int T = 16;
  localparam int P_IDLE = 0, P_WAIT = 1, P_COMMIT = 2, P_DONE = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1, new_game = 1'b0, game_over = 1'b0, req_x = 1'b0, req_o = 1'b0;
  logic [8:0] cuadro_x = '0, cuadro_o = '0, x = '0, o = '0;
  logic [8:0] almacenar_x, almacenar_o;
  logic       ack, nack, timeout, turnoX;
  logic [3:0] move_count;
  logic [2:0] state;

  always #5 clk = ~clk;

  turn_arbiter #(.TIMEOUT_CYCLES(T), .TMR_W(5)) dut (
    .clk_100MHz(clk), .reset(reset), .new_game(new_game), .game_over(game_over),
    .req_x(req_x), .cuadro_x(cuadro_x), .req_o(req_o), .cuadro_o(cuadro_o),
    .x(x), .o(o), .almacenar_x(almacenar_x), .almacenar_o(almacenar_o),
    .ack(ack), .nack(nack), .timeout(timeout), .turnoX(turnoX),
    .move_count(move_count), .state(state)
  );

  int checks = 0, passes = 0, fails = 0;

  // Game-level model: phase, whose turn, time spent this turn, moves, board
  int         ph = P_IDLE, elapsed = 0, moves = 0;
  bit         turnx = 1'b1;
  logic [8:0] bx = '0, bo = '0, pend = '0;
  logic [8:0] e_ax = '0, e_ao = '0;
  bit         e_ack = 0, e_nack = 0, e_to = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int exp_state();
    case (ph)
      P_WAIT:   return turnx ? 1 : 3;
      P_COMMIT: return turnx ? 2 : 4;
      P_DONE:   return 5;
      default:  return 0;
    endcase
  endfunction

  task automatic play_square(input logic [8:0] s);
    ph = P_COMMIT;
    pend = s;
    e_ack = 1;
    if (turnx) e_ax = s; else e_ao = s;
  endtask

  task automatic step(input string tag);
    bit         rq;
    logic [8:0] cq;
    int         fk;
    e_ax = '0; e_ao = '0; e_ack = 0; e_nack = 0; e_to = 0;
    if (reset) begin
      ph = P_IDLE; turnx = 1; moves = 0; elapsed = 0;
    end else if (new_game) begin
      ph = P_WAIT; turnx = 1; moves = 0; elapsed = 0; bx = '0; bo = '0;
    end else begin
      case (ph)
        P_WAIT: begin
          rq = turnx ? req_x : req_o;
          cq = turnx ? cuadro_x : cuadro_o;
          if (game_over) begin
            ph = P_DONE; elapsed = 0;
          end else if (rq && $countones(cq) == 1 && (cq & (bx | bo)) == 0) begin
            play_square(cq); elapsed = 0;
          end else begin
            if (rq) e_nack = 1;
            if (elapsed == T - 1) begin
              e_to = 1; elapsed = 0;
`ifdef TURN_ARBITER_AUTO_MOVE_EN
              fk = -1;
              for (int i = 8; i >= 0; i--) if (!(bx[i] | bo[i])) fk = i;
              if (fk < 0) ph = P_DONE;
              else play_square(9'(1 << fk));
`else
              fk = 0;
              turnx = !turnx;
`endif
            end else elapsed++;
          end
        end
        P_COMMIT: begin
          if (turnx) bx = bx | pend; else bo = bo | pend;
          moves++; turnx = !turnx; elapsed = 0;
          ph = (moves == 9) ? P_DONE : P_WAIT;
        end
        default: ;
      endcase
    end
    @(posedge clk);
    #1;
    x = bx; o = bo;
    chk({tag, ".state"}, 32'(state), 32'(exp_state()));
    chk({tag, ".turnoX"}, 32'(turnoX), 32'(turnx));
    chk({tag, ".move_count"}, 32'(move_count), 32'(moves));
    chk({tag, ".almacenar_x"}, 32'(almacenar_x), 32'(e_ax));
    chk({tag, ".almacenar_o"}, 32'(almacenar_o), 32'(e_ao));
    chk({tag, ".ack"}, 32'(ack), 32'(e_ack));
    chk({tag, ".nack"}, 32'(nack), 32'(e_nack));
    chk({tag, ".timeout"}, 32'(timeout), 32'(e_to));
  endtask

  initial begin
    logic [8:0] one;
    int sqs[9];
    int mode;
    one = 9'd1;
    sqs = '{4, 0, 1, 2, 3, 5, 6, 7, 8};

    #1;
    step("reset0"); step("reset1");
    reset = 0; new_game = 1; step("newgame"); new_game = 0;

    req_x = 1; cuadro_x = 9'b000010000; step("x_commit");
    req_x = 0; step("to_wait_o");

    req_o = 1; cuadro_o = 9'b000010000; step("o_occupied");
    cuadro_o = 9'b000000011; step("o_multihot");
    req_o = 0; req_x = 1; cuadro_x = 9'b000000001; step("x_out_of_turn");
    req_x = 0; req_o = 1; cuadro_o = 9'b000000001; step("o_commit");
    req_o = 0; step("to_wait_x");
    for (int i = 0; i < T + 1; i++) step("x_timeout");
    step("after_timeout");

    new_game = 1; step("ng_full"); new_game = 0;
    for (int k = 0; k < 9; k++) begin
      if (k % 2 == 0) begin req_x = 1; cuadro_x = one << sqs[k]; end
      else            begin req_o = 1; cuadro_o = one << sqs[k]; end
      step("full_commit");
      req_x = 0; req_o = 0;
      step("full_next");
    end
    req_x = 1; cuadro_x = 9'b000000001; req_o = 1; cuadro_o = 9'b000000010;
    step("done_ignore"); step("done_ignore2");
    req_x = 0; req_o = 0;
    new_game = 1; step("ng_after_done"); new_game = 0;

    req_x = 1; cuadro_x = 9'b000000001; step("go_x"); req_x = 0; step("go_wait_o");
    game_over = 1; req_o = 1; cuadro_o = 9'b000000010; step("go_with_req");
    game_over = 0; req_o = 0; step("go_done");

    new_game = 1; step("ng_rst"); new_game = 0;
    req_x = 1; cuadro_x = 9'b000000001; step("rc_x"); req_x = 0; step("rc_wait_o");
    req_o = 1; cuadro_o = 9'b000000010; step("rc_commit_o"); req_o = 0;
    reset = 1; #1;
    chk("rst_in_commit.almacenar_o", 32'(almacenar_o), 32'd0);
    step("rst_in_commit_next");
    reset = 0;

    for (int i = 0; i < 900; i++) begin
      mode = (i / 40) % 3;
      reset     = ($urandom_range(0, 249) == 0);
      new_game  = ($urandom_range(0, 59) == 0);
      game_over = ($urandom_range(0, 99) == 0);
      if (mode == 2) begin
        req_x = 0; req_o = 0;
      end else begin
        req_x = ($urandom_range(0, 1) == 1);
        req_o = ($urandom_range(0, 1) == 1);
        if (mode == 0) begin
          cuadro_x = one << $urandom_range(0, 8);
          cuadro_o = one << $urandom_range(0, 8);
        end else begin
          cuadro_x = 9'($urandom);
          cuadro_o = 9'($urandom);
        end
      end
      step("rand");
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
